ex_hazard_ctrl: RTL and testbench

//  Pipeline controller for the EX stage of the 5-stage RV32I core.
//  - Selects EX operand forwarding sources.
//  - Detects load-use hazards and stalls IF/ID for LOAD_LAT cycles while bubbling ID/EX.
//  - Resolves branches/jumps from the EX comparator flags and drives the PC redirect plus IF/ID, ID/EX flushes.
//  - Keeps saturating stall/flush performance counters.

---
 rtl/ex_ctrl_pkg.sv | 43 ++++
 rtl/ex_br_decide.sv | 44 ++++
 rtl/ex_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_ctrl_pkg.sv
// ex_ctrl_pkg
// Shared types and constants for the EX-stage pipeline controller:
//   fwd_sel_e  - operand source select (regfile / MEM / WB)
//   state_e    - load-use stall FSM states
//   BR_*       - conditional branch funct3 encodings
//   fwd_pick() - per-operand forwarding priority (MEM over WB, x0 never forwarded)
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } state_e;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // The youngest producer (MEM) holds the newest value, so it wins over WB.
    function automatic fwd_sel_e fwd_pick(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_wren,
        input logic [4:0] wb_rd,
        input logic       wb_wren
    );
        if (mem_wren && (mem_rd != 5'd0) && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_wren && (wb_rd != 5'd0) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/ex_br_decide.sv
// ex_br_decide
// Combinational branch/jump resolution for the EX stage.
// Ports:
//   i_br_f3   funct3 of the EX branch
//   i_brlt    comparator less-than
//   i_breq    comparator equal
//   i_is_br   EX instruction is a conditional branch
//   i_is_jmp  EX instruction is JAL/JALR
//   i_valid   EX holds a real instruction
//   o_take    redirect the PC this cycle
//   o_brun    request an unsigned compare from the comparator
module ex_br_decide
    import ex_ctrl_pkg::*;
(
    input  logic [2:0] i_br_f3,
    input  logic       i_brlt,
    input  logic       i_breq,
    input  logic       i_is_br,
    input  logic       i_is_jmp,
    input  logic       i_valid,
    output logic       o_take,
    output logic       o_brun
);

    logic cond;

    // NOTE: assign a default before the case so no path leaves cond unassigned
    // (an incomplete combinational assignment infers a latch).
    always_comb begin
        cond = 1'b0;
        case (i_br_f3)
            BR_BEQ:           cond = i_breq;
            BR_BNE:           cond = ~i_breq;
            BR_BLT, BR_BLTU:  cond = i_brlt;
            BR_BGE, BR_BGEU:  cond = ~i_brlt;
            default:          cond = 1'b0;  // 010/011 are not branches
        endcase
    end

    // funct3[1] separates the unsigned variants (BLTU/BGEU) from the signed ones.
    assign o_brun = i_br_f3[1];
    assign o_take = i_valid & (i_is_jmp | (i_is_br & cond));

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
// EX-stage pipeline controller for the 5-stage RV32I core: operand forwarding
// selects, load-use stall/bubble, branch/jump redirect and flushes, plus
// saturating stall/flush performance counters.
// Ports:
//   i_clk, i_rst_n               clock, synchronous active-low reset
//   i_id_*                       source registers read by the instruction in ID
//   i_ex_*                       instruction in EX (operands, rd, load, branch info)
//   i_brlt, i_breq               EX comparator flags
//   i_mem_rd_*, i_wb_rd_*        writeback destinations of MEM and WB
//   i_perf_clr                   clear both performance counters
//   o_brun                       unsigned compare request
//   o_fwd_a_sel, o_fwd_b_sel     EX operand sources (00 RF, 01 MEM, 10 WB)
//   o_pc_sel                     IF takes the EX ALU target
//   o_stall                      hold PC and IF/ID
//   o_flush_id, o_flush_ex       clear IF/ID, ID/EX valid at next edge
//   o_stall_cnt, o_flush_cnt     stall cycles / taken redirects
// All controls are combinational; only the FSM, bubble counter and perf
// counters are registered. Controls read 0 while reset is asserted.
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_use,
    input  logic             i_id_rs2_use,
    input  logic             i_ex_valid,
    input  logic [4:0]       i_ex_rs1_addr,
    input  logic [4:0]       i_ex_rs2_addr,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_rd_wren,
    input  logic             i_ex_mem_rden,
    input  logic             i_ex_is_br,
    input  logic             i_ex_is_jmp,
    input  logic [2:0]       i_ex_br_f3,
    input  logic             i_brlt,
    input  logic             i_breq,
    input  logic [4:0]       i_mem_rd_addr,
    input  logic             i_mem_rd_wren,
    input  logic [4:0]       i_wb_rd_addr,
    input  logic             i_wb_rd_wren,
    input  logic             i_perf_clr,
    output logic             o_brun,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic             o_pc_sel,
    output logic             o_stall,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int              LAT_W    = 2;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LOAD_LAT - 1);

    state_e           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic     take;
    logic     brun;
    logic     hazard;
    logic     stall_c;
    logic     flush_id_c;
    logic     flush_ex_c;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    ex_br_decide u_br_decide (
        .i_br_f3  (i_ex_br_f3),
        .i_brlt   (i_brlt),
        .i_breq   (i_breq),
        .i_is_br  (i_ex_is_br),
        .i_is_jmp (i_ex_is_jmp),
        .i_valid  (i_ex_valid),
        .o_take   (take),
        .o_brun   (brun)
    );

    assign fwd_a = fwd_pick(i_ex_rs1_addr, i_mem_rd_addr, i_mem_rd_wren, i_wb_rd_addr, i_wb_rd_wren);
    assign fwd_b = fwd_pick(i_ex_rs2_addr, i_mem_rd_addr, i_mem_rd_wren, i_wb_rd_addr, i_wb_rd_wren);

    // A load in EX whose rd is read by the instruction in ID cannot be forwarded in time.
    assign hazard = i_ex_valid & i_ex_mem_rden & i_ex_rd_wren & (i_ex_rd_addr != 5'd0) &
                    ((i_id_rs1_use & (i_ex_rd_addr == i_id_rs1_addr)) |
                     (i_id_rs2_use & (i_ex_rd_addr == i_id_rs2_addr)));

    // A redirect discards ID anyway, so it overrides any pending load-use stall.
    always_comb begin
        stall_c    = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        if (take) begin
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end else if ((state == LDSTALL) || hazard) begin
            stall_c    = 1'b1;
            flush_ex_c = 1'b1;
        end
    end

    assign o_brun      = i_rst_n & brun;
    assign o_fwd_a_sel = i_rst_n ? fwd_a : FWD_RF;
    assign o_fwd_b_sel = i_rst_n ? fwd_b : FWD_RF;
    assign o_pc_sel    = i_rst_n & take;
    assign o_stall     = i_rst_n & stall_c;
    assign o_flush_id  = i_rst_n & flush_id_c;
    assign o_flush_ex  = i_rst_n & flush_ex_c;
    assign o_stall_cnt = stall_cnt;
    assign o_flush_cnt = flush_cnt;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= RUN;
            lat_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (take) begin
                state   <= RUN;
                lat_cnt <= '0;
            end else begin
                case (state)
                    RUN: begin
                        // With a single bubble the hazard cycle itself is the whole stall.
                        if (hazard && (LOAD_LAT > 1)) begin
                            lat_cnt <= LAT_LOAD;
                            state   <= LDSTALL;
                        end
                    end
                    LDSTALL: begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                        if (lat_cnt == LAT_W'(1))
                            state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end

            if (i_perf_clr)
                stall_cnt <= '0;
            else if (stall_c && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);

            if (i_perf_clr)
                flush_cnt <= '0;
            else if (take && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl
// Self-checking bench for ex_hazard_ctrl. Two instances share the pipeline inputs:
//   dut  : LOAD_LAT=2, CNT_W=32 (forwarding, branches, 2-cycle load-use stall)
//   dut2 : LOAD_LAT=3, CNT_W=4  (reset mid-stall, counter saturation/clear)
// Inputs are applied 1 time unit after a rising edge; check() compares the
// response of that cycle shortly afterwards, before the falling edge.
module tb_ex_hazard_ctrl;

  typedef enum int {S_CTRL, S_CTRL2, S_SCNT, S_FCNT, S_SCNT2} sel_e;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst2_n, perf_clr, perf_clr2;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_rs1_use, id_rs2_use, ex_valid, ex_rd_wren, ex_mem_rden;
  logic       ex_is_br, ex_is_jmp, brlt, breq, mem_wren, wb_wren;
  logic [2:0] ex_f3;

  logic        brun, pc_sel, stall, flush_id, flush_ex;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;
  logic        brun2, pc_sel2, stall2, flush_id2, flush_ex2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic [3:0]  stall_cnt2, flush_cnt2;

  ex_hazard_ctrl #(.LOAD_LAT(2), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2),
    .i_id_rs1_use(id_rs1_use), .i_id_rs2_use(id_rs2_use),
    .i_ex_valid(ex_valid), .i_ex_rs1_addr(ex_rs1), .i_ex_rs2_addr(ex_rs2),
    .i_ex_rd_addr(ex_rd), .i_ex_rd_wren(ex_rd_wren), .i_ex_mem_rden(ex_mem_rden),
    .i_ex_is_br(ex_is_br), .i_ex_is_jmp(ex_is_jmp), .i_ex_br_f3(ex_f3),
    .i_brlt(brlt), .i_breq(breq),
    .i_mem_rd_addr(mem_rd), .i_mem_rd_wren(mem_wren),
    .i_wb_rd_addr(wb_rd), .i_wb_rd_wren(wb_wren),
    .i_perf_clr(perf_clr),
    .o_brun(brun), .o_fwd_a_sel(fwd_a), .o_fwd_b_sel(fwd_b),
    .o_pc_sel(pc_sel), .o_stall(stall), .o_flush_id(flush_id), .o_flush_ex(flush_ex),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  ex_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n),
    .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2),
    .i_id_rs1_use(id_rs1_use), .i_id_rs2_use(id_rs2_use),
    .i_ex_valid(ex_valid), .i_ex_rs1_addr(ex_rs1), .i_ex_rs2_addr(ex_rs2),
    .i_ex_rd_addr(ex_rd), .i_ex_rd_wren(ex_rd_wren), .i_ex_mem_rden(ex_mem_rden),
    .i_ex_is_br(ex_is_br), .i_ex_is_jmp(ex_is_jmp), .i_ex_br_f3(ex_f3),
    .i_brlt(brlt), .i_breq(breq),
    .i_mem_rd_addr(mem_rd), .i_mem_rd_wren(mem_wren),
    .i_wb_rd_addr(wb_rd), .i_wb_rd_wren(wb_wren),
    .i_perf_clr(perf_clr2),
    .o_brun(brun2), .o_fwd_a_sel(fwd_a2), .o_fwd_b_sel(fwd_b2),
    .o_pc_sel(pc_sel2), .o_stall(stall2), .o_flush_id(flush_id2), .o_flush_ex(flush_ex2),
    .o_stall_cnt(stall_cnt2), .o_flush_cnt(flush_cnt2)
  );

  // Expected control word: {brun, fwd_a, fwd_b, pc_sel, stall, flush_id, flush_ex}
  function automatic logic [31:0] c(input logic b, input logic [1:0] fa, input logic [1:0] fb,
                                    input logic pc, input logic st, input logic fid, input logic fex);
    return {23'd0, b, fa, fb, pc, st, fid, fex};
  endfunction

  function automatic logic [31:0] actual(input sel_e s);
    case (s)
      S_CTRL:  return {23'd0, brun, fwd_a, fwd_b, pc_sel, stall, flush_id, flush_ex};
      S_CTRL2: return {23'd0, brun2, fwd_a2, fwd_b2, pc_sel2, stall2, flush_id2, flush_ex2};
      S_SCNT:  return stall_cnt;
      S_FCNT:  return flush_cnt;
      default: return {28'd0, stall_cnt2};
    endcase
  endfunction

  task automatic check(input sel_e s, input logic [31:0] v, input string name);
    logic [31:0] act;
    #1;
    act = actual(s);
    checks++;
    if (act !== v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
    ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_rd_wren = 0; ex_mem_rden = 0;
    ex_is_br = 0; ex_is_jmp = 0; ex_f3 = 3'b000; brlt = 0; breq = 0;
    mem_rd = 0; mem_wren = 0; wb_rd = 0; wb_wren = 0;
    perf_clr = 0; perf_clr2 = 0;
  endtask

  // Load to x7 in EX, instruction in ID reads x7 through rs2.
  task automatic load_use();
    idle();
    ex_valid = 1; ex_mem_rden = 1; ex_rd_wren = 1; ex_rd = 5'd7;
    id_rs2 = 5'd7; id_rs2_use = 1;
  endtask

  task automatic branch(input logic [2:0] f3, input logic lt, input logic eq);
    idle();
    ex_valid = 1; ex_is_br = 1; ex_f3 = f3; brlt = lt; breq = eq;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 0; rst2_n = 0;

    // Reset: controls gated low even with a jump, forwarding match and f3[1]=1.
    step();
    ex_valid = 1; ex_is_jmp = 1; ex_f3 = 3'b010; ex_rs1 = 5; mem_rd = 5; mem_wren = 1;
    check(S_CTRL, c(0, 2'b00, 2'b00, 0, 0, 0, 0), "reset_ctrl");
    step();
    check(S_CTRL, 32'd0, "reset_ctrl2");
    check(S_SCNT, 32'd0, "reset_stall_cnt");
    check(S_FCNT, 32'd0, "reset_flush_cnt");
    step();
    idle(); rst_n = 1;
    check(S_CTRL, 32'd0, "idle_after_reset");

    // Forwarding
    step();
    ex_valid = 1; ex_rs1 = 5; mem_rd = 5; mem_wren = 1; wb_rd = 5; wb_wren = 1;
    check(S_CTRL, c(0, 2'b01, 2'b00, 0, 0, 0, 0), "fwd_a_mem_wins");
    step();
    mem_rd = 0;
    check(S_CTRL, c(0, 2'b10, 2'b00, 0, 0, 0, 0), "fwd_a_wb");
    step();
    ex_rs1 = 0; mem_rd = 0; wb_rd = 0;
    check(S_CTRL, c(0, 2'b00, 2'b00, 0, 0, 0, 0), "fwd_x0_never");
    step();
    ex_rs2 = 9; mem_rd = 9; mem_wren = 0; wb_rd = 9; wb_wren = 1;
    check(S_CTRL, c(0, 2'b00, 2'b10, 0, 0, 0, 0), "fwd_b_wb");
    step();
    ex_rs1 = 9; mem_wren = 1;
    check(S_CTRL, c(0, 2'b01, 2'b01, 0, 0, 0, 0), "fwd_ab_mem");

    // Load-use, LOAD_LAT=2
    step();
    load_use();
    check(S_CTRL, c(0, 2'b00, 2'b00, 0, 1, 0, 1), "lu_stall1");
    step();
    idle();
    check(S_CTRL, c(0, 2'b00, 2'b00, 0, 1, 0, 1), "lu_stall2");
    step();
    idle();
    check(S_CTRL, 32'd0, "lu_released");
    check(S_SCNT, 32'd2, "lu_stall_cnt");
    step();
    load_use(); id_rs2_use = 0; id_rs1 = 7; id_rs1_use = 0;
    check(S_CTRL, 32'd0, "lu_rs1_unused");

    // Taken BLTU
    step();
    branch(3'b110, 1, 0);
    check(S_CTRL, c(1, 2'b00, 2'b00, 1, 0, 1, 1), "bltu_taken");
    step();
    idle();
    check(S_CTRL, 32'd0, "bltu_one_cycle");
    check(S_FCNT, 32'd1, "flush_cnt_1");

    // Jump beats a same-cycle load-use hazard; no LDSTALL afterwards
    step();
    load_use(); ex_is_jmp = 1;
    check(S_CTRL, c(0, 2'b00, 2'b00, 1, 0, 1, 1), "take_over_hazard");
    step();
    idle();
    check(S_CTRL, 32'd0, "no_stall_after_take");
    check(S_FCNT, 32'd2, "flush_cnt_2");

    // Branch conditions
    step();
    branch(3'b101, 1, 0);
    check(S_CTRL, c(0, 2'b00, 2'b00, 0, 0, 0, 0), "bge_not_taken");
    step();
    branch(3'b010, 1, 1);
    check(S_CTRL, c(1, 2'b00, 2'b00, 0, 0, 0, 0), "f3_010_never");
    step();
    branch(3'b011, 0, 1);
    check(S_CTRL, c(1, 2'b00, 2'b00, 0, 0, 0, 0), "f3_011_never");
    step();
    branch(3'b100, 0, 0);
    check(S_CTRL, c(0, 2'b00, 2'b00, 0, 0, 0, 0), "blt_not_taken");
    step();
    branch(3'b001, 0, 1);
    check(S_CTRL, c(0, 2'b00, 2'b00, 0, 0, 0, 0), "bne_not_taken");
    step();
    branch(3'b111, 0, 0);
    check(S_CTRL, c(1, 2'b00, 2'b00, 1, 0, 1, 1), "bgeu_taken");
    step();
    branch(3'b000, 0, 1); ex_valid = 0; ex_is_jmp = 1;
    check(S_CTRL, c(0, 2'b00, 2'b00, 0, 0, 0, 0), "bubble_no_take");
    step();
    idle(); perf_clr = 1;
    check(S_FCNT, 32'd3, "flush_cnt_3");
    step();
    idle();
    check(S_FCNT, 32'd0, "flush_cnt_cleared");

    // dut2 (LOAD_LAT=3): full 3-cycle stall, then reset in mid-LDSTALL
    step();
    idle(); rst2_n = 1;
    check(S_CTRL2, 32'd0, "d2_idle");
    check(S_SCNT2, 32'd0, "d2_cnt0");
    step();
    load_use();
    check(S_CTRL2, c(0, 2'b00, 2'b00, 0, 1, 0, 1), "d2_stall1");
    step();
    idle();
    check(S_CTRL2, c(0, 2'b00, 2'b00, 0, 1, 0, 1), "d2_stall2");
    step();
    idle();
    check(S_CTRL2, c(0, 2'b00, 2'b00, 0, 1, 0, 1), "d2_stall3");
    step();
    idle();
    check(S_CTRL2, 32'd0, "d2_released");
    check(S_SCNT2, 32'd3, "d2_stall_cnt3");
    step();
    load_use();
    check(S_CTRL2, c(0, 2'b00, 2'b00, 0, 1, 0, 1), "d2_enter_ldstall");
    step();
    load_use(); rst2_n = 0;
    check(S_CTRL2, 32'd0, "d2_reset_gated");
    step();
    idle(); rst2_n = 1;
    check(S_CTRL2, 32'd0, "d2_state_run_after_reset");
    check(S_SCNT2, 32'd0, "d2_cnt_after_reset");

    // Saturation with CNT_W=4: 20 consecutive stall cycles
    for (int i = 0; i < 20; i++) begin
      step();
      load_use();
      check(S_SCNT2, (i < 15) ? 32'(i) : 32'd15, "d2_cnt_sat");
    end
    step();
    load_use(); perf_clr2 = 1;
    check(S_SCNT2, 32'd15, "d2_saturated");
    check(S_CTRL2, c(0, 2'b00, 2'b00, 0, 1, 0, 1), "d2_stall_with_clr");
    step();
    load_use();
    check(S_SCNT2, 32'd0, "d2_clr_wins");
    step();
    idle();
    check(S_SCNT2, 32'd1, "d2_count_resumes");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
